// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//
// Fetch stage of the 5-stage RV32I pipeline. This block owns the program
// counter and drives the instruction-memory read handshake. It passes PC+4,
// the fetched instruction and a combined stall to the IF/ID register.
//
// Taken branches/jumps from EX redirect the PC. If a redirect arrives while a
// memory access is still in flight, the access is allowed to finish in the
// FLUSH state and its data is thrown away. Wrong-path words are replaced with
// NOP (addi x0,x0,0).
//
// Ports:
//   CLK             clock, all state updates on posedge
//   RESET           asynchronous active-high reset
//   BRANCH_TAKEN    redirect request from EX (one cycle)
//   BRANCH_TARGET   redirect address, bits [1:0] forced to 00
//   HAZARD_STALL    load-use stall, freezes the PC
//   IMEM_BUSY_WAIT  instruction memory access in progress
//   IMEM_READDATA   instruction word from memory
//   IMEM_READ       read request (1 whenever out of reset)
//   IMEM_ADDRESS    fetch address (= PC)
//   PC_INCREMENT4   PC+4 to IF/ID
//   INSTRUCTION     instruction to IF/ID (NOP when squashed)
//   BUSY_WAIT       stall to IF/ID (register holds when 1)
//   STALL_COUNT     stall-cycle counter, present only when the macro
//                   IFU_PERF_COUNT_EN is defined
module instruction_fetch_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        HAZARD_STALL,
  input  logic        IMEM_BUSY_WAIT,
  input  logic [31:0] IMEM_READDATA,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  output logic [31:0] PC_INCREMENT4,
  output logic [31:0] INSTRUCTION,
  output logic        BUSY_WAIT
`ifdef IFU_PERF_COUNT_EN
  ,
  output logic [31:0] STALL_COUNT
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    RUN,
    FLUSH
  } fetch_state_t;

  fetch_state_t state;
  fetch_state_t next_state;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic [31:0]  redirect_pc;
  logic [31:0]  next_redirect_pc;
  logic [31:0]  target;

  // Masking all bits, rather than slicing, keeps every target bit in use.
  assign target = BRANCH_TARGET & 32'hFFFF_FFFC;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= RUN;
      pc          <= '0;
      redirect_pc <= '0;
    end else begin
      state       <= next_state;
      pc          <= next_pc;
      redirect_pc <= next_redirect_pc;
    end
  end

  // In RUN, a branch that arrives during a busy access is parked in
  // redirect_pc because the in-flight access must complete first. In FLUSH,
  // a newer branch replaces the parked target, so the youngest redirect wins.
  // A branch that coincides with the access completing is used directly.
  always_comb begin
    next_state       = state;
    next_pc          = pc;
    next_redirect_pc = redirect_pc;
    case (state)
      RUN: begin
        if (BRANCH_TAKEN) begin
          if (IMEM_BUSY_WAIT) begin
            next_redirect_pc = target;
            next_state       = FLUSH;
          end else begin
            next_pc = target;
          end
        end else if (!IMEM_BUSY_WAIT && !HAZARD_STALL) begin
          next_pc = pc + 32'd4;
        end
      end
      FLUSH: begin
        if (IMEM_BUSY_WAIT) begin
          if (BRANCH_TAKEN) begin
            next_redirect_pc = target;
          end
        end else begin
          next_pc    = BRANCH_TAKEN ? target : redirect_pc;
          next_state = RUN;
        end
      end
      default: next_state = RUN;
    endcase
  end

  // The PC is cleared asynchronously, so the address and PC+4 outputs reach
  // their reset values (0 and 4) without any extra gating.
  always_comb begin
    IMEM_READ     = !RESET;
    IMEM_ADDRESS  = pc;
    PC_INCREMENT4 = pc + 32'd4;
    INSTRUCTION   = NOP;
    BUSY_WAIT     = 1'b0;
    if (!RESET) begin
      BUSY_WAIT = IMEM_BUSY_WAIT | HAZARD_STALL | (state == FLUSH);
      if (state == RUN && !BRANCH_TAKEN) begin
        INSTRUCTION = IMEM_READDATA;
      end
    end
  end

`ifdef IFU_PERF_COUNT_EN
  // The counter saturates so that long runs never wrap back to small values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      STALL_COUNT <= '0;
    end else if (BUSY_WAIT && STALL_COUNT != 32'hFFFF_FFFF) begin
      STALL_COUNT <= STALL_COUNT + 32'd1;
    end
  end
`endif

endmodule
